// File: rtl/fft_avg_pkg.sv
// fft_avg_pkg: FSM states, default widths and avg_log2 clamp shared by fft_power_avg
package fft_avg_pkg;
  typedef enum logic [1:0] {CLEAR, IDLE, ACCUM} fsm_e;
  localparam int DATA_W_DEF = 16;
  localparam int AVG_MAX_DEF = 8;
  localparam int PWR_W = 2*DATA_W_DEF+1;
  localparam int ACC_W = PWR_W+AVG_MAX_DEF;
  localparam int OUT_W = 32;
  function automatic logic [3:0] clamp_avg(input logic [3:0] a, input int amax);
    return (int'(a) > amax) ? 4'(amax) : a;
  endfunction
endpackage

// File: rtl/fft_avg_acc_ram.sv
// fft_avg_acc_ram: simple dual-port accumulator RAM with registered read
module fft_avg_acc_ram #(
  parameter int DW = 41,
  parameter int ADDR_W = 10
) (
  input  logic              ps_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);
  logic [DW-1:0] mem [1<<ADDR_W];
  always_ff @(posedge ps_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_power_avg.sv
// fft_power_avg: per-bin |X|^2 averaged over 2^avg_log2 FFT frames, streamed out per group.
// Define FFT_AVG_PEAK_EN to add peak_bin/peak_val outputs.
module fft_power_avg
  import fft_avg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NFFT_LOG2 = 10,
  parameter int AVG_MAX = AVG_MAX_DEF
) (
  input  logic                 ps_clk,
  input  logic                 ps_aresetn,
  input  logic [2*DATA_W-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  input  logic                 enable,
  input  logic [3:0]           avg_log2,
  output logic                 frame_err
`ifdef FFT_AVG_PEAK_EN
  ,
  output logic [NFFT_LOG2-1:0] peak_bin,
  output logic [OUT_W-1:0]     peak_val
`endif
);
  localparam int PW = 2*DATA_W+1;
  localparam int AW = PW+AVG_MAX;
  localparam logic [NFFT_LOG2-1:0] BIN_MAX = '1;
  fsm_e state, state_nx;
  logic [NFFT_LOG2-1:0] bin_cnt, s1_bin, s2_bin, s3_bin, ram_wa;
  logic [AVG_MAX-1:0] frame_cnt, grp_max;
  logic [3:0] avg_q, cur_avg, s1_avg, s2_avg, s3_avg;
  logic acc_in, stall, halt, stop_q, busy, is_last, fin, wrap;
  logic s1_v, s2_v, s3_v, s1_fin, s2_fin, s3_fin, s1_last, s2_last, s3_last;
  logic signed [DATA_W-1:0] s1_re, s1_im;
  logic signed [2*DATA_W-1:0] re_x, im_x;
  logic [2*DATA_W-1:0] s2_rr, s2_ii;
  logic [PW-1:0] s3_pwr;
  logic [AW-1:0] ram_rd, ram_wd, sum;
  logic ram_we;
  assign stall = m_axis_tvalid && !m_axis_tready;
  // once enable drops, stop at the next frame boundary and hold off until CLEAR
  assign halt = stop_q || (!enable && bin_cnt == '0);
  assign busy = s1_v || s2_v || s3_v || m_axis_tvalid;
  assign s_axis_tready = state == ACCUM && !stall && !halt;
  assign acc_in = s_axis_tvalid && s_axis_tready;
  assign cur_avg = (bin_cnt == '0 && frame_cnt == '0) ? clamp_avg(avg_log2, AVG_MAX) : avg_q;
  assign grp_max = AVG_MAX'((32'd1 << cur_avg) - 32'd1);
  assign is_last = bin_cnt == BIN_MAX;
  assign fin = frame_cnt == grp_max;
  assign wrap = is_last || s_axis_tlast;
  always_comb begin
    state_nx = state;
    if (state == CLEAR && bin_cnt == BIN_MAX) state_nx = enable ? ACCUM : IDLE;
    if (state == IDLE && enable) state_nx = ACCUM;
    if (state == ACCUM && halt && !busy) state_nx = CLEAR;
  end
  always_ff @(posedge ps_clk) begin
    if (!ps_aresetn) begin
      state <= CLEAR;
      bin_cnt <= '0;
      frame_cnt <= '0;
      avg_q <= '0;
      stop_q <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      frame_err <= acc_in && (s_axis_tlast != is_last);
      if (state == CLEAR) begin
        bin_cnt <= bin_cnt + NFFT_LOG2'(1);
        frame_cnt <= '0;
        stop_q <= 1'b0;
      end else if (acc_in) begin
        bin_cnt <= wrap ? '0 : bin_cnt + NFFT_LOG2'(1);
        if (wrap) frame_cnt <= fin ? '0 : frame_cnt + AVG_MAX'(1);
        if (bin_cnt == '0 && frame_cnt == '0) avg_q <= cur_avg;
      end
      if (state == ACCUM && halt) stop_q <= 1'b1;
    end
  end
  assign re_x = (2*DATA_W)'(s1_re);
  assign im_x = (2*DATA_W)'(s1_im);
  assign sum = AW'(s3_pwr) + ram_rd;
  always_ff @(posedge ps_clk) begin
    if (!ps_aresetn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tdata <= '0;
    end else if (!stall) begin
      s1_v <= acc_in;
      s2_v <= s1_v;
      s3_v <= s2_v;
      m_axis_tvalid <= s3_v && s3_fin;
      m_axis_tlast <= s3_v && s3_fin && s3_last;
      m_axis_tdata <= OUT_W'(sum >> s3_avg);
    end
  end
  always_ff @(posedge ps_clk) begin
    if (!stall) begin
      s1_re <= s_axis_tdata[DATA_W-1:0];
      s1_im <= s_axis_tdata[2*DATA_W-1:DATA_W];
      s1_bin <= bin_cnt;
      s1_fin <= fin;
      s1_last <= is_last;
      s1_avg <= cur_avg;
      s2_rr <= $unsigned(re_x * re_x);
      s2_ii <= $unsigned(im_x * im_x);
      s2_bin <= s1_bin;
      s2_fin <= s1_fin;
      s2_last <= s1_last;
      s2_avg <= s1_avg;
      s3_pwr <= PW'(s2_rr) + PW'(s2_ii);
      s3_bin <= s2_bin;
      s3_fin <= s2_fin;
      s3_last <= s2_last;
      s3_avg <= s2_avg;
    end
  end
  // final frame of a group zeroes its word so the next group starts fresh
  assign ram_we = state == CLEAR || (!stall && s3_v);
  assign ram_wa = state == CLEAR ? bin_cnt : s3_bin;
  assign ram_wd = (state == CLEAR || s3_fin) ? '0 : sum;
  fft_avg_acc_ram #(.DW(AW), .ADDR_W(NFFT_LOG2)) u_ram (
    .ps_clk(ps_clk),
    .we(ram_we),
    .waddr(ram_wa),
    .wdata(ram_wd),
    .re(!stall),
    .raddr(s2_bin),
    .rdata(ram_rd)
  );
`ifdef FFT_AVG_PEAK_EN
  logic [NFFT_LOG2-1:0] m_bin, run_bin;
  logic [OUT_W-1:0] run_val;
  logic run_new, hs, take;
  assign hs = m_axis_tvalid && m_axis_tready;
  // strict compare on ascending bins keeps the lowest bin on ties
  assign take = run_new || m_axis_tdata > run_val;
  always_ff @(posedge ps_clk) begin
    if (!ps_aresetn) begin
      m_bin <= '0;
      run_bin <= '0;
      run_val <= '0;
      run_new <= 1'b1;
      peak_bin <= '0;
      peak_val <= '0;
    end else begin
      if (!stall) m_bin <= s3_bin;
      if (hs) begin
        run_new <= m_axis_tlast;
        run_val <= take ? m_axis_tdata : run_val;
        run_bin <= take ? m_bin : run_bin;
        if (m_axis_tlast) begin
          peak_val <= take ? m_axis_tdata : run_val;
          peak_bin <= take ? m_bin : run_bin;
        end
      end
    end
  end
`endif
endmodule
